// File: rtl/verif_sink_a.sv
// Receiving responder for the A-side valid/ready operand interface: applies a
// selectable backpressure pattern, tallies accepted operands, flags initiator protocol errors.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_STALL | fixed-wait mode holding a_ready low while wait_cnt drains
// ST_OPEN  | fixed-wait mode holding a_ready high until the next handshake
module verif_sink_a #(
    parameter logic [3:0]  BP_WAIT = 4'd3,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        a_valid,
    input  logic [7:0]  a_operand,
    input  logic [1:0]  bp_mode,
    output logic        a_ready,
    output logic        rx_strobe,
    output logic [7:0]  last_operand,
    output logic [15:0] rx_count,
    output logic [15:0] rx_sum,
    output logic        err_drop,
    output logic        err_unstable
);

    localparam logic [0:0] ST_STALL = 1'b0;
    localparam logic [0:0] ST_OPEN  = 1'b1;

    localparam logic [1:0] MODE_ALWAYS = 2'd0;
    localparam logic [1:0] MODE_NEVER  = 2'd1;
    localparam logic [1:0] MODE_FIXED  = 2'd2;
    localparam logic [1:0] MODE_RANDOM = 2'd3;

    logic        hs;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nxt;
    logic        lfsr_fb;
    logic [0:0]  state_q;
    logic [0:0]  state_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_nxt;
    logic        ready_nxt;
    logic        stall_q;
    logic [7:0]  op_q;

    assign hs = a_valid && a_ready;

    // Right-shifting Fibonacci form: taps 16,14,13,11 sit at bits 0,2,3,5.
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign lfsr_nxt = {lfsr_fb, lfsr_q[15:1]};

    always_comb begin
        state_nxt = state_q;
        wait_nxt  = wait_cnt;
        case (state_q)
            ST_STALL: begin
                if (wait_cnt != 4'd0) wait_nxt = wait_cnt - 4'd1;
                else                  state_nxt = ST_OPEN;
            end
            default: begin
                if (hs) begin
                    state_nxt = ST_STALL;
                    wait_nxt  = BP_WAIT;
                end
            end
        endcase
    end

    always_comb begin
        ready_nxt = 1'b0;
        case (bp_mode)
            MODE_ALWAYS: ready_nxt = 1'b1;
            MODE_NEVER:  ready_nxt = 1'b0;
            MODE_FIXED:  ready_nxt = (state_nxt == ST_OPEN);
            MODE_RANDOM: ready_nxt = lfsr_nxt[0];
            default:     ready_nxt = 1'b0;
        endcase
    end

    // The fixed-wait sequencer freezes outside its own mode so it resumes where it left off.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_STALL;
            wait_cnt <= BP_WAIT;
            lfsr_q   <= SEED;
            a_ready  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_nxt;
            a_ready <= ready_nxt;
            if (bp_mode == MODE_FIXED) begin
                state_q  <= state_nxt;
                wait_cnt <= wait_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_strobe    <= 1'b0;
            last_operand <= 8'h00;
            rx_count     <= 16'h0000;
            rx_sum       <= 16'h0000;
        end else begin
            rx_strobe <= hs;
            if (hs) begin
                last_operand <= a_operand;
                rx_count     <= rx_count + 16'd1;
                rx_sum       <= rx_sum + {8'h00, a_operand};
            end
        end
    end

    // op_q holds the operand seen on the previous stalled cycle for the stability compare.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q      <= 1'b0;
            op_q         <= 8'h00;
            err_drop     <= 1'b0;
            err_unstable <= 1'b0;
        end else begin
            stall_q <= a_valid && !a_ready;
            if (a_valid && !a_ready) op_q <= a_operand;
            if (stall_q && !a_valid) err_drop <= 1'b1;
            if (stall_q && a_valid && (a_operand != op_q)) err_unstable <= 1'b1;
        end
    end

endmodule

// File: doc/verif_sink_a.md
# verif_sink_a

Verification responder for the A-side valid/ready operand interface: the receiving end that drives `a_ready` and consumes `a_operand` from a stimulus initiator. It applies a selectable backpressure pattern, counts and checksums accepted operands, and flags initiator protocol violations. It is bench-only VIP, sitting opposite the A-side initiator in the block-level testbench.

## Interface
- `BP_WAIT`, 3: stall cycles before each `a_ready` assertion in fixed-wait mode (4-bit, 0..15)
- `SEED`, 16'hACE1: LFSR reset value for random mode; must be nonzero
- `clk`  in  1  clock; all state updates on the rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `a_valid`  in  1  initiator valid
- `a_operand`  in  8  initiator payload
- `bp_mode`  in  2  backpressure select: 0 always-ready, 1 never-ready, 2 fixed-wait, 3 LFSR-random
- `a_ready`  out  1  responder ready, registered
- `rx_strobe`  out  1  one-cycle pulse per accepted transfer
- `last_operand`  out  8  most recently accepted operand
- `rx_count`  out  16  accepted transfers, wraps mod 2^16
- `rx_sum`  out  16  sum of accepted operands, zero-extended, mod 2^16
- `err_drop`  out  1  sticky: valid withdrawn before handshake
- `err_unstable`  out  1  sticky: operand changed while stalled

## Operation
- Handshake: `a_valid && a_ready` sampled at a rising edge. On that edge: `last_operand <= a_operand`, `rx_count <= rx_count+1`, `rx_sum <= rx_sum + {8'h00,a_operand}`, `rx_strobe <= 1`. Otherwise `rx_strobe <= 0`.
- `a_ready` next value by `bp_mode` (mode read each edge; a change takes effect on that edge):
  - 0: 1. 1: 0. 3: `lfsr[0]` (post-advance value).
  - 2, states STALL (`a_ready`=0) and OPEN (`a_ready`=1):
    - STALL, `wait_cnt != 0`: decrement.
    - STALL, `wait_cnt == 0`: go OPEN.
    - OPEN, no handshake: stay.
    - OPEN, handshake: go STALL, reload `wait_cnt <= BP_WAIT`.
  - `wait_cnt` and the STALL/OPEN state update only in mode 2. On entry to mode 2, resume from the held values.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every mode.
- Stall tracking:
  - `stall_q <= a_valid && !a_ready`.
  - `op_q <= a_operand` whenever `stall_q` is being set.
- `err_drop` sets when `stall_q && !a_valid`.
- `err_unstable` sets when `stall_q && a_valid && a_operand != op_q`.
- Both error flags are sticky until reset. Both may set on the same edge.
- Operand X/Z content is not checked.

## Timing
- Reset values:
  - `a_ready`=0, `rx_strobe`=0, `last_operand`=8'h00, `rx_count`=0, `rx_sum`=0, both errors 0.
  - `wait_cnt`=BP_WAIT, state STALL, `lfsr`=SEED, `stall_q`=0.
- Reset asserted mid-transfer clears everything immediately (async). The in-flight transfer is not counted.
- Acceptance latency: `rx_strobe`, `rx_count`, `rx_sum` and `last_operand` update on the handshake edge. They are visible the cycle after `a_valid && a_ready`.
- Mode 0 throughput: `a_ready`=1 from the first edge after reset release; one transfer per cycle.
- Mode 2:
  - `a_ready` rises BP_WAIT+1 edges after reset release or after a handshake edge.
  - With `a_valid` held high, the transfer period is BP_WAIT+2 cycles. BP_WAIT=0 gives 50% throughput.
- `a_ready` does not depend on `a_valid` in any mode. It may be high with no valid present.
- Counter wrap: `rx_count` 16'hFFFF + 1 = 0 and `rx_sum` wraps silently. Neither wrap sets an error.

## Test plan
- Reset then mode 0, operands 8'h01..8'h05 back-to-back -> `a_ready`=1 the cycle after release, five `rx_strobe` pulses, `rx_count`=5, `rx_sum`=16'h000F, `last_operand`=8'h05.
- Mode 2, BP_WAIT=3, `a_valid` held with 8'hA5 -> `a_ready` high 4 edges after reset, `rx_count` increments every 5 cycles, no errors.
- Mode 1, `a_valid` high with 8'h3C for 3 cycles, then operand changes to 8'h3D -> `err_unstable`=1, `err_drop`=0, `rx_count`=0.
- Mode 1, `a_valid` high 2 cycles then low -> `err_drop`=1, sticky across further traffic until `rstn` low.
- Mode 0, 256 transfers of 8'hFF -> `rx_sum`=16'hFF00, `rx_count`=256. Preload via 65,536 transfers of 8'h00 -> `rx_count` wraps to 0.
- Mode 3, SEED=16'hACE1, 100 cycles -> `a_ready` sequence matches reference LFSR model bit-for-bit. Assert `rstn` mid-stall -> all outputs return to reset values asynchronously.
